// File: rtl/cache_axi_refill_pkg.sv
// Shared types and AXI constants for the cache miss handler.
package cache_axi_refill_pkg;

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RESP} state_t;

    // Burst attributes the parent wrapper ties onto the AXI channels.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Byte-offset bits within one line of line_words 32-bit words.
    function automatic int line_off_w(input int line_words);
        return $clog2(4 * line_words);
    endfunction

endpackage

// File: rtl/cache_axi_refill_if.sv
// Cache request/response plus AXI4 read and write channels of the miss handler.
// master = the refill block, slave = cache + memory side.
interface cache_axi_refill_if #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_W-1:0]       req_addr;
    logic                    req_wb;
    logic [ADDR_W-1:0]       req_wb_addr;
    logic [32*LINE_WORDS-1:0] req_wb_line;
    logic                    resp_valid;
    logic [32*LINE_WORDS-1:0] resp_line;
    logic                    resp_err;

    logic [ADDR_W-1:0]       araddr;
    logic                    arvalid;
    logic                    arready;
    logic [31:0]             rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    logic [ADDR_W-1:0]       awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [31:0]             wdata;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        input  req_valid, req_addr, req_wb, req_wb_addr, req_wb_line,
        output req_ready, resp_valid, resp_line, resp_err,
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wlast, wvalid, bready,
        input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        output req_valid, req_addr, req_wb, req_wb_addr, req_wb_line,
        input  req_ready, resp_valid, resp_line, resp_err,
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wlast, wvalid, bready,
        output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/cache_axi_refill.sv
// Blocking cache miss handler: optional dirty-victim write-back burst, then line refill burst.
// Latency: resp_valid LINE_WORDS+2 cycles after accept (read only), more with write-back.
// Backpressure: one transaction in flight, req_ready low while busy; AXI VALIDs held until READY.
module cache_axi_refill
    import cache_axi_refill_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input logic                clk,
    input logic                rstn,
    cache_axi_refill_if.master bus
);

    localparam int OFF_W = line_off_w(LINE_WORDS);
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    state_t                   state, state_nx;
    logic [CNT_W-1:0]         cnt;
    logic                     r_full;
    logic [ADDR_W-1:0]        rd_addr, wb_addr;
    logic [32*LINE_WORDS-1:0] wb_line, line_q;
    logic                     err_q;

    logic req_rdy, aw_vld, w_vld, w_last, b_rdy, ar_vld, r_rdy, resp_vld;
    logic accept, w_hs, r_hs, b_hs;

    assign accept = req_rdy & bus.req_valid;
    assign w_hs   = w_vld & bus.wready;
    assign r_hs   = r_rdy & bus.rvalid;
    assign b_hs   = b_rdy & bus.bvalid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // All channel VALID/READY outputs are pure state decodes, never a function of the peer's READY.
    always_comb begin
        state_nx = state;
        req_rdy  = 1'b0;
        aw_vld   = 1'b0;
        w_vld    = 1'b0;
        w_last   = 1'b0;
        b_rdy    = 1'b0;
        ar_vld   = 1'b0;
        r_rdy    = 1'b0;
        resp_vld = 1'b0;
        unique case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (bus.req_valid) state_nx = bus.req_wb ? AW : AR;
            end
            AW: begin
                aw_vld = 1'b1;
                if (bus.awready) state_nx = W;
            end
            W: begin
                w_vld  = 1'b1;
                w_last = (cnt == LAST_BEAT);
                if (bus.wready && w_last) state_nx = B;
            end
            B: begin
                b_rdy = 1'b1;
                if (bus.bvalid) state_nx = AR;
            end
            AR: begin
                ar_vld = 1'b1;
                if (bus.arready) state_nx = R;
            end
            R: begin
                r_rdy = 1'b1;
                if (bus.rvalid && bus.rlast) state_nx = RESP;
            end
            RESP: begin
                resp_vld = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One counter serves both bursts: it wraps to 0 after a full write-back, ready for the refill.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            r_full  <= 1'b0;
            rd_addr <= '0;
            wb_addr <= '0;
            wb_line <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            r_full  <= 1'b0;
            rd_addr <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wb_addr <= {bus.req_wb_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wb_line <= bus.req_wb_line;
            err_q   <= 1'b0;
        end else begin
            if (w_hs) cnt <= cnt + 1'b1;
            if (b_hs) err_q <= err_q | bus.bresp[1];
            if (r_hs) begin
                err_q <= err_q | bus.rresp[1];
                // Beats past a full line are drained but not stored.
                if (!r_full) begin
                    line_q[{cnt, 5'd0} +: 32] <= bus.rdata;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BEAT) r_full <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready  = req_rdy;
    assign bus.resp_valid = resp_vld;
    assign bus.resp_line  = line_q;
    assign bus.resp_err   = err_q;
    assign bus.araddr     = rd_addr;
    assign bus.arvalid    = ar_vld;
    assign bus.rready     = r_rdy;
    assign bus.awaddr     = wb_addr;
    assign bus.awvalid    = aw_vld;
    assign bus.wdata      = wb_line[{cnt, 5'd0} +: 32];
    assign bus.wlast      = w_last;
    assign bus.wvalid     = w_vld;
    assign bus.bready     = b_rdy;

    logic unused_ok;
    assign unused_ok = ^{bus.req_addr[OFF_W-1:0], bus.req_wb_addr[OFF_W-1:0],
                         bus.rresp[0], bus.bresp[0]};

endmodule
